mos6502s_mem_arbiter: RTL and testbench

- Two-port arbiter/sequencer that shares the single-port 6502 system memory (32K RAM below 0x8000, 32K ROM at 0x8000 and above) between the CPU bus master and a DMA/loader master.
- Each transfer is latched and driven into the memory for exactly one access cycle, then acknowledged with registered read data.
- Arbitration is round-robin or fixed CPU priority, with a DMA lock for bursts and rejection of writes to the ROM half.

---
 rtl/mos6502s_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mos6502s_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mos6502s_mem_arbiter.sv
// Two-master (CPU / DMA) sequencer for the single-port 6502 system memory.
// Each transfer runs IDLE -> ACCESS -> RESP; writes to the ROM half are rejected.
module mos6502s_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter bit FAIR       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_rw,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_rw,
    input  logic                  dma_lock,
    output logic                  dma_ack,
    output logic                  dma_err,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rw,
    output logic                  mem_cs,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DMA = 1'b1;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  lock_dma_q, lock_dma_d;
    logic                  err_pending_q, err_pending_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
    logic                  lat_rw_q, lat_rw_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;

    logic blocked;
    logic dma_wins;
    logic in_resp;

    assign blocked = ~lat_rw_q & lat_addr_q[ADDR_WIDTH-1];

    // A held lock beats fairness; the lock only matters when both are asking.
    always_comb begin
        dma_wins = dma_req;
        if (cpu_req && dma_req) begin
            if (lock_dma_q) begin
                dma_wins = 1'b1;
            end else begin
                dma_wins = FAIR ? (last_grant_q == GRANT_CPU) : 1'b0;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        lock_dma_d    = lock_dma_q;
        err_pending_d = err_pending_q;
        lat_addr_d    = lat_addr_q;
        lat_wdata_d   = lat_wdata_q;
        lat_rw_d      = lat_rw_q;
        cpu_rdata_d   = cpu_rdata_q;
        dma_rdata_d   = dma_rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_d = dma_wins ? GRANT_DMA : GRANT_CPU;
                    if (dma_wins) begin
                        lat_addr_d  = dma_addr;
                        lat_wdata_d = dma_wdata;
                        lat_rw_d    = dma_rw;
                    end else begin
                        lat_addr_d  = cpu_addr;
                        lat_wdata_d = cpu_wdata;
                        lat_rw_d    = cpu_rw;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_rw_q) begin
                    if (grant_q == GRANT_DMA) begin
                        dma_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                    end
                end
                err_pending_d = blocked;
                state_d       = RESP;
            end
            RESP: begin
                last_grant_d = grant_q;
                lock_dma_d   = (grant_q == GRANT_DMA) & dma_lock;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= GRANT_CPU;
            last_grant_q  <= GRANT_DMA;
            lock_dma_q    <= 1'b0;
            err_pending_q <= 1'b0;
            lat_addr_q    <= '0;
            lat_wdata_q   <= '0;
            lat_rw_q      <= 1'b1;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            lock_dma_q    <= lock_dma_d;
            err_pending_q <= err_pending_d;
            lat_addr_q    <= lat_addr_d;
            lat_wdata_q   <= lat_wdata_d;
            lat_rw_q      <= lat_rw_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
        end
    end

    // Gating with rst keeps a reset cycle from committing a write or completing a transfer.
    assign in_resp   = (state_q == RESP) & ~rst;
    assign cpu_ack   = in_resp & (grant_q == GRANT_CPU);
    assign dma_ack   = in_resp & (grant_q == GRANT_DMA);
    assign cpu_err   = cpu_ack & err_pending_q;
    assign dma_err   = dma_ack & err_pending_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

    assign mem_addr  = lat_addr_q;
    assign mem_wdata = lat_wdata_q;
    assign mem_rw    = lat_rw_q;
    assign mem_cs    = (state_q == ACCESS) & ~rst & ~blocked;

endmodule

// File: tb/tb_mos6502s_mem_arbiter.sv
// Scoreboard bench for mos6502s_mem_arbiter: a fair instance backed by a RAM/ROM
// model, plus a fixed-priority instance sharing the same memory image for reads.
module tb_mos6502s_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_rw, cpu_ack, cpu_err;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_rw, dma_lock, dma_ack, dma_err;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_rw, mem_cs;

    logic        f_cpu_req, f_cpu_ack, f_cpu_err;
    logic [15:0] f_cpu_addr;
    logic [7:0]  f_cpu_rdata;
    logic        f_dma_req, f_dma_ack, f_dma_err;
    logic [15:0] f_dma_addr;
    logic [7:0]  f_dma_rdata;
    logic [15:0] f_mem_addr;
    logic [7:0]  f_mem_wdata, f_mem_rdata;
    logic        f_mem_rw, f_mem_cs;

    typedef struct {
        bit         isDma;
        bit         err;
        bit         checkData;
        logic [7:0] data;
    } exp_t;

    exp_t sbQueue[$];
    int   checks = 0;
    int   errors = 0;
    int   cycleCount = 0;
    int   lastAck = -1;
    bit   spacingOn = 1'b0;
    bit   romWriteSeen = 1'b0;
    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    mos6502s_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .FAIR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rw(dma_rw),
        .dma_lock(dma_lock), .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_cs(mem_cs),
        .mem_rdata(mem_rdata)
    );

    mos6502s_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .FAIR(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .cpu_req(f_cpu_req), .cpu_addr(f_cpu_addr), .cpu_wdata(8'h00), .cpu_rw(1'b1),
        .cpu_ack(f_cpu_ack), .cpu_err(f_cpu_err), .cpu_rdata(f_cpu_rdata),
        .dma_req(f_dma_req), .dma_addr(f_dma_addr), .dma_wdata(8'h00), .dma_rw(1'b1),
        .dma_lock(1'b0), .dma_ack(f_dma_ack), .dma_err(f_dma_err), .dma_rdata(f_dma_rdata),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_rw(f_mem_rw), .mem_cs(f_mem_cs),
        .mem_rdata(f_mem_rdata)
    );

    // RAM image is addr[7:0]^0x5A, ROM image is addr[7:0]^0xC3; only RAM accepts writes.
    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = (i < 32768) ? (8'(i) ^ 8'h5A) : (8'(i) ^ 8'hC3);
        end
    end

    assign mem_rdata   = mem[mem_addr];
    assign f_mem_rdata = mem[f_mem_addr];

    always @(posedge clk) begin
        cycleCount++;
        if (mem_cs && !mem_rw) begin
            if (mem_addr[15]) romWriteSeen <= 1'b1;
            else mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectAck(input bit isDma, input bit err, input bit checkData, input logic [7:0] data);
        exp_t e;
        e.isDma = isDma; e.err = err; e.checkData = checkData; e.data = data;
        sbQueue.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every ack, sampled on the falling edge.
    always @(negedge clk) begin
        if (cpu_ack || dma_ack) begin
            checkOutput("single_ack", 32'(cpu_ack & dma_ack), 32'd0);
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_ack", {30'd0, dma_ack, cpu_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sbQueue.pop_front();
                checkOutput("ack_source", 32'(dma_ack), 32'(e.isDma));
                checkOutput("ack_err", 32'(e.isDma ? dma_err : cpu_err), 32'(e.err));
                if (e.checkData)
                    checkOutput("ack_rdata", 32'(e.isDma ? dma_rdata : cpu_rdata), 32'(e.data));
            end
            if (spacingOn) begin
                if (lastAck >= 0) checkOutput("ack_spacing", 32'(cycleCount - lastAck), 32'd3);
                lastAck = cycleCount;
            end
        end
    end

    task automatic waitAck(input bit isDma, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            got = isDma ? dma_ack : cpu_ack;
        end
        checkOutput(isDma ? "dma_ack_seen" : "cpu_ack_seen", 32'(got), 32'd1);
    endtask

    // Called just after a rising edge; returns just after the edge that ends RESP.
    task automatic applyStimulus(input bit isDma, input logic [15:0] a, input logic [7:0] d,
                                 input logic rw, input int expLat);
        int lat;
        if (isDma) begin
            dma_addr = a; dma_wdata = d; dma_rw = rw; dma_req = 1'b1;
        end else begin
            cpu_addr = a; cpu_wdata = d; cpu_rw = rw; cpu_req = 1'b1;
        end
        waitAck(isDma, lat);
        if (expLat > 0) checkOutput("ack_latency", 32'(lat), 32'(expLat));
        @(posedge clk);
        #1;
        if (isDma) dma_req = 1'b0;
        else cpu_req = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        checkOutput("rst_dma_ack", 32'(dma_ack), 32'd0);
        checkOutput("rst_errs", {30'd0, cpu_err, dma_err}, 32'd0);
        checkOutput("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("rst_dma_rdata", 32'(dma_rdata), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_mem_rw", 32'(mem_rw), 32'd1);
        checkOutput("rst_mem_cs", 32'(mem_cs), 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int cpuCnt;
        int dmaCnt;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_rw = 1'b1;
        dma_req = 1'b0; dma_addr = '0; dma_wdata = '0; dma_rw = 1'b1; dma_lock = 1'b0;
        f_cpu_req = 1'b0; f_cpu_addr = 16'h0010; f_dma_req = 1'b0; f_dma_addr = 16'h0020;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkResetState();

        $display("[TB] CPU write then read of 0x0200");
        @(posedge clk); #1;
        expectAck(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 16'h0200, 8'hA5, 1'b0, 3);
        expectAck(1'b0, 1'b0, 1'b1, 8'hA5);
        applyStimulus(1'b0, 16'h0200, 8'h00, 1'b1, 3);

        $display("[TB] Round-robin with both masters requesting");
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        expectAck(1'b0, 1'b0, 1'b1, 8'h4A);
        expectAck(1'b1, 1'b0, 1'b1, 8'h7A);
        expectAck(1'b0, 1'b0, 1'b1, 8'h4A);
        expectAck(1'b1, 1'b0, 1'b1, 8'h7A);
        lastAck = -1;
        spacingOn = 1'b1;
        fork
            begin
                applyStimulus(1'b0, 16'h0010, 8'h00, 1'b1, 0);
                applyStimulus(1'b0, 16'h0010, 8'h00, 1'b1, 0);
            end
            begin
                applyStimulus(1'b1, 16'h0020, 8'h00, 1'b1, 0);
                applyStimulus(1'b1, 16'h0020, 8'h00, 1'b1, 0);
            end
        join
        spacingOn = 1'b0;

        $display("[TB] DMA locked burst of four writes, CPU waiting");
        for (int i = 0; i < 4; i++) expectAck(1'b1, 1'b0, 1'b0, 8'h00);
        expectAck(1'b0, 1'b0, 1'b1, 8'h4A);
        fork
            begin
                dma_lock = 1'b1;
                for (int i = 0; i < 4; i++)
                    applyStimulus(1'b1, 16'h0400 + 16'(i), 8'hB0 + 8'(i), 1'b0, 0);
                dma_lock = 1'b0;
            end
            begin
                waitAck(1'b1, lat);
                @(posedge clk); #1;
                applyStimulus(1'b0, 16'h0010, 8'h00, 1'b1, 0);
            end
        join
        expectAck(1'b0, 1'b0, 1'b1, 8'hB2);
        applyStimulus(1'b0, 16'h0402, 8'h00, 1'b1, 0);

        $display("[TB] ROM write rejection and RAM/ROM boundary");
        expectAck(1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 16'h8000, 8'h55, 1'b0, 3);
        checkOutput("rom_write_cs", 32'(romWriteSeen), 32'd0);
        expectAck(1'b1, 1'b0, 1'b1, 8'hC3);
        applyStimulus(1'b1, 16'h8000, 8'h00, 1'b1, 0);
        expectAck(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 16'h7FFF, 8'h66, 1'b0, 0);
        expectAck(1'b0, 1'b0, 1'b1, 8'h66);
        applyStimulus(1'b0, 16'h7FFF, 8'h00, 1'b1, 0);

        $display("[TB] Reset during the ACCESS cycle of a write");
        expectAck(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 16'h0300, 8'h11, 1'b0, 0);
        cpu_addr = 16'h0300; cpu_wdata = 8'h77; cpu_rw = 1'b0; cpu_req = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        checkResetState();
        @(posedge clk); #1;
        expectAck(1'b0, 1'b0, 1'b1, 8'h11);
        applyStimulus(1'b0, 16'h0300, 8'h00, 1'b1, 0);

        $display("[TB] Address change during ACCESS and rdata hold");
        expectAck(1'b0, 1'b0, 1'b1, 8'hA5);
        cpu_addr = 16'h0200; cpu_rw = 1'b1; cpu_req = 1'b1;
        @(posedge clk); #1 cpu_addr = 16'h0010;
        waitAck(1'b0, lat);
        @(posedge clk); #1 cpu_req = 1'b0;
        expectAck(1'b1, 1'b0, 1'b1, 8'h7A);
        applyStimulus(1'b1, 16'h0020, 8'h00, 1'b1, 0);
        checkOutput("cpu_rdata_hold", 32'(cpu_rdata), 32'hA5);

        $display("[TB] Fixed priority instance starves DMA");
        f_cpu_req = 1'b1; f_dma_req = 1'b1;
        cpuCnt = 0; dmaCnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (f_cpu_ack) cpuCnt++;
            if (f_dma_ack) dmaCnt++;
        end
        checkOutput("fixed_cpu_acks", 32'(cpuCnt), 32'd4);
        checkOutput("fixed_dma_acks", 32'(dmaCnt), 32'd0);
        checkOutput("fixed_cpu_rdata", 32'(f_cpu_rdata), 32'h4A);
        @(posedge clk); #1 f_cpu_req = 1'b0;
        dmaCnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (f_dma_ack) dmaCnt++;
        end
        checkOutput("fixed_dma_served", 32'(dmaCnt), 32'd1);
        checkOutput("fixed_dma_rdata", 32'(f_dma_rdata), 32'h7A);
        @(posedge clk); #1 f_dma_req = 1'b0;

        for (int i = 0; i < 20 && sbQueue.size() > 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
